// File: rtl/resp_chk_pkg.sv
// Shared types and helpers for the response-side MISR checker and the matching
// stimulus-side signature generator.
package resp_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_CHECK = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  localparam logic [31:0] DEF_POLY = 32'h04C11DB7;
  localparam logic [31:0] DEF_SEED = 32'h0000_0000;

  // Upper bounds for the width-generic fold; callers zero-extend into these.
  localparam int FOLD_MAX_Y   = 512;
  localparam int FOLD_MAX_SIG = 64;
  localparam int FOLD_IDX_W   = $clog2(FOLD_MAX_SIG);

  // XOR every s_w-bit chunk of the low y_w bits of y; missing top bits act as zero.
  function automatic logic [FOLD_MAX_SIG-1:0] fold(input logic [FOLD_MAX_Y-1:0] y,
                                                   input int y_w,
                                                   input int s_w);
    logic [FOLD_MAX_SIG-1:0] f;
    logic [FOLD_IDX_W-1:0]   idx;
    f = {FOLD_MAX_SIG{1'b0}};
    for (int i = 0; i < FOLD_MAX_Y; i++) begin
      idx = FOLD_IDX_W'(i % s_w);
      if (i < y_w) begin
        f[idx] = f[idx] ^ y[i];
      end else begin
        f = f;
      end
    end
    return f;
  endfunction

endpackage

// File: rtl/resp_misr_checker_if.sv
// Response bus, run control and status bundle between the sampled design and the checker.
interface resp_misr_checker_if #(
  parameter int Y_WIDTH   = 127,
  parameter int SIG_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) ();

  logic                 start;
  logic                 y_valid;
  logic [Y_WIDTH-1:0]   y;
  logic [SIG_WIDTH-1:0] exp_sig;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [SIG_WIDTH-1:0] sig;
  logic [CNT_WIDTH-1:0] sample_cnt;

  modport master (
    output start, y_valid, y, exp_sig,
    input  busy, done, pass, sig, sample_cnt
  );

  modport slave (
    input  start, y_valid, y, exp_sig,
    output busy, done, pass, sig, sample_cnt
  );

endinterface

// File: rtl/misr_fold_step.sv
// Combinational fold of one response sample plus one MISR shift/feedback step.
module misr_fold_step
  import resp_chk_pkg::*;
#(
  parameter int                   Y_WIDTH   = 127,
  parameter int                   SIG_WIDTH = 32,
  parameter logic [SIG_WIDTH-1:0] POLY      = DEF_POLY
) (
  input  logic [SIG_WIDTH-1:0] sig,
  input  logic [Y_WIDTH-1:0]   y,
  output logic [SIG_WIDTH-1:0] sig_next
);

  logic [FOLD_MAX_Y-1:0]   y_ext_s;
  logic [FOLD_MAX_SIG-1:0] fold_full_s;
  logic [SIG_WIDTH-1:0]    fold_s;
  logic [SIG_WIDTH-1:0]    fb_s;
  logic                    unused_fold_s;

  assign y_ext_s       = FOLD_MAX_Y'(y);
  assign fold_full_s   = fold(y_ext_s, Y_WIDTH, SIG_WIDTH);
  assign fold_s        = fold_full_s[SIG_WIDTH-1:0];
  assign unused_fold_s = ^fold_full_s[FOLD_MAX_SIG-1:SIG_WIDTH];

  // Feedback taps are applied only when the bit shifted out is set.
  assign fb_s     = sig[SIG_WIDTH-1] ? POLY : {SIG_WIDTH{1'b0}};
  assign sig_next = {sig[SIG_WIDTH-2:0], 1'b0} ^ fb_s ^ fold_s;

endmodule

// File: rtl/resp_misr_checker.sv
// Compacts valid response samples into a MISR signature, counts them and, after a
// programmed number of samples, compares against an expected signature.
module resp_misr_checker
  import resp_chk_pkg::*;
#(
  parameter int                   Y_WIDTH   = 127,
  parameter int                   SIG_WIDTH = 32,
  parameter logic [SIG_WIDTH-1:0] POLY      = DEF_POLY,
  parameter logic [SIG_WIDTH-1:0] SEED      = DEF_SEED,
  parameter int                   SAMPLES   = 21,
  parameter int                   CNT_WIDTH = 16
) (
  input logic               clk,
  input logic               rst,
  resp_misr_checker_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(SAMPLES - 1);

  // The counter must reach SAMPLES without wrapping and the fold helper has fixed bounds.
  if ((SAMPLES < 1) || (64'(SAMPLES) >= (64'd1 << CNT_WIDTH))) begin : g_bad_samples
    $error("resp_misr_checker: SAMPLES must be in [1, 2**CNT_WIDTH)");
  end
  if ((Y_WIDTH > FOLD_MAX_Y) || (SIG_WIDTH >= FOLD_MAX_SIG) || (SIG_WIDTH < 2)) begin : g_bad_width
    $error("resp_misr_checker: Y_WIDTH/SIG_WIDTH outside fold helper bounds");
  end

  state_e               state_r,  state_nxt_s;
  logic [SIG_WIDTH-1:0] sig_r,    sig_nxt_s;
  logic [CNT_WIDTH-1:0] cnt_r,    cnt_nxt_s;
  logic                 pass_r,   pass_nxt_s;
  logic                 busy_r;
  logic                 done_r;
  logic [SIG_WIDTH-1:0] misr_nxt_s;

  misr_fold_step #(
    .Y_WIDTH  (Y_WIDTH),
    .SIG_WIDTH(SIG_WIDTH),
    .POLY     (POLY)
  ) u_step (
    .sig     (sig_r),
    .y       (bus.y),
    .sig_next(misr_nxt_s)
  );

  // Next-state and datapath selection; start wins over a coincident sample.
  always_comb begin
    state_nxt_s = state_r;
    sig_nxt_s   = sig_r;
    cnt_nxt_s   = cnt_r;
    pass_nxt_s  = pass_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_nxt_s = ST_RUN;
          sig_nxt_s   = SEED;
          cnt_nxt_s   = CNT_ZERO;
          pass_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RUN: begin
        if (bus.y_valid) begin
          sig_nxt_s = misr_nxt_s;
          cnt_nxt_s = cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            state_nxt_s = ST_CHECK;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_CHECK: begin
        pass_nxt_s  = (sig_r == bus.exp_sig);
        state_nxt_s = ST_DONE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        sig_nxt_s   = SEED;
        cnt_nxt_s   = CNT_ZERO;
        pass_nxt_s  = 1'b0;
      end
    endcase
  end

  // State and status registers; busy/done derive from the next state so they track it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      sig_r   <= SEED;
      cnt_r   <= CNT_ZERO;
      pass_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      sig_r   <= sig_nxt_s;
      cnt_r   <= cnt_nxt_s;
      pass_r  <= pass_nxt_s;
      busy_r  <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_CHECK);
      done_r  <= (state_nxt_s == ST_DONE);
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.pass       = pass_r;
  assign bus.sig        = sig_r;
  assign bus.sample_cnt = cnt_r;

endmodule

// File: tb/tb_resp_misr_checker.sv
// Randomised bench for resp_misr_checker with SAMPLES=1, 2 and 21 instances sharing stimulus,
// checked against a sample-queue signature model.
module tb_resp_misr_checker;

  localparam int          YW   = 127;
  localparam int          SW   = 32;
  localparam int          CW   = 16;
  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           y_valid = 1'b0;
  logic [YW-1:0]  y = '0;
  logic [SW-1:0]  exp_sig = '0;

  int err_cnt = 0;
  int chk_cnt = 0;

  resp_misr_checker_if #(.Y_WIDTH(YW), .SIG_WIDTH(SW), .CNT_WIDTH(CW)) b1 ();
  resp_misr_checker_if #(.Y_WIDTH(YW), .SIG_WIDTH(SW), .CNT_WIDTH(CW)) b2 ();
  resp_misr_checker_if #(.Y_WIDTH(YW), .SIG_WIDTH(SW), .CNT_WIDTH(CW)) b21 ();

  assign b1.start  = start;  assign b1.y_valid  = y_valid;  assign b1.y  = y;  assign b1.exp_sig  = exp_sig;
  assign b2.start  = start;  assign b2.y_valid  = y_valid;  assign b2.y  = y;  assign b2.exp_sig  = exp_sig;
  assign b21.start = start;  assign b21.y_valid = y_valid;  assign b21.y = y;  assign b21.exp_sig = exp_sig;

  resp_misr_checker #(.SAMPLES(1))  u_dut1  (.clk(clk), .rst(rst), .bus(b1));
  resp_misr_checker #(.SAMPLES(2))  u_dut2  (.clk(clk), .rst(rst), .bus(b2));
  resp_misr_checker #(.SAMPLES(21)) u_dut21 (.clk(clk), .rst(rst), .bus(b21));

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] expv);
    chk_cnt++;
    if (act !== expv) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, expv);
    end
  endtask

  // Reference: split the zero-extended sample into 32-bit chunks and XOR them.
  function automatic logic [31:0] ref_fold(input logic [YW-1:0] v);
    logic [127:0] w;
    w = {1'b0, v};
    return w[31:0] ^ w[63:32] ^ w[95:64] ^ w[127:96];
  endfunction

  function automatic logic [31:0] ref_sig(input logic [YW-1:0] q[$]);
    logic [31:0] s;
    s = 32'h0;
    foreach (q[i]) s = (s << 1) ^ (s[31] ? POLY : 32'h0) ^ ref_fold(q[i]);
    return s;
  endfunction

  function automatic logic [YW-1:0] rand_y();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[YW-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; y_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [YW-1:0] v);
    y = v; y_valid = 1'b1;
    step();
    y_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      y = rand_y();
      step();
    end
  endtask

  task automatic check_idle21(input string tag);
    check_val({tag, "_busy"}, 64'(b21.busy), 64'd0);
    check_val({tag, "_done"}, 64'(b21.done), 64'd0);
    check_val({tag, "_pass"}, 64'(b21.pass), 64'd0);
    check_val({tag, "_sig"},  64'(b21.sig),  64'd0);
    check_val({tag, "_cnt"},  64'(b21.sample_cnt), 64'd0);
  endtask

  logic [YW-1:0] fold_y [3];
  logic [31:0]   fold_e [3];
  logic [YW-1:0] q[$];
  logic [31:0]   rs;

  initial begin
    fold_y[0] = '0; fold_y[0][32]  = 1'b1; fold_e[0] = 32'h0000_0001;
    fold_y[1] = '0; fold_y[1][126] = 1'b1; fold_e[1] = 32'h4000_0000;
    fold_y[2] = '1;                        fold_e[2] = 32'h8000_0000;

    step();
    check_idle21("reset");
    rst = 1'b0;

    // Single-sample run.
    do_reset();
    exp_sig = 32'h1;
    pulse_start();
    check_val("s1_busy_after_start", 64'(b1.busy), 64'd1);
    send(127'd1);
    check_val("s1_sig", 64'(b1.sig), 64'h1);
    check_val("s1_cnt", 64'(b1.sample_cnt), 64'd1);
    check_val("s1_done_early", 64'(b1.done), 64'd0);
    step();
    check_val("s1_done", 64'(b1.done), 64'd1);
    check_val("s1_pass", 64'(b1.pass), 64'd1);
    check_val("s1_busy_end", 64'(b1.busy), 64'd0);

    // Fold boundaries, restarting from DONE each time.
    for (int k = 0; k < 3; k++) begin
      exp_sig = fold_e[k];
      pulse_start();
      send(fold_y[k]);
      check_val("fold_sig", 64'(b1.sig), 64'(fold_e[k]));
      check_val("fold_ref", 64'(b1.sig), 64'(ref_fold(fold_y[k])));
      step();
      check_val("fold_pass", 64'(b1.pass), 64'd1);
    end

    // Two back-to-back samples, then a rerun with a wrong expectation.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      exp_sig = (r == 0) ? 32'h2 : 32'h3;
      pulse_start();
      check_val("s2_done_drop", 64'(b2.done), 64'd0);
      send(127'd1);
      send(127'd0);
      check_val("s2_sig", 64'(b2.sig), 64'h2);
      step();
      check_val("s2_done", 64'(b2.done), 64'd1);
      check_val("s2_pass", 64'(b2.pass), (r == 0) ? 64'd1 : 64'd0);
    end

    // 21 zero samples with gaps; start during RUN must not restart.
    do_reset();
    exp_sig = 32'h0;
    pulse_start();
    for (int i = 0; i < 21; i++) begin
      send('0);
      if (i == 5 || i == 12) begin
        pulse_start();
        check_val("run_start_ignored", 64'(b21.sample_cnt), 64'(i + 1));
      end
      if (i < 20) gap($urandom_range(0, 2));
    end
    check_val("z_cnt", 64'(b21.sample_cnt), 64'd21);
    check_val("z_sig", 64'(b21.sig), 64'd0);
    check_val("z_busy", 64'(b21.busy), 64'd1);
    step();
    check_val("z_done", 64'(b21.done), 64'd1);
    check_val("z_pass", 64'(b21.pass), 64'd1);

    // start together with y_valid in DONE: the sample is dropped.
    y = rand_y(); start = 1'b1; y_valid = 1'b1;
    step();
    start = 1'b0; y_valid = 1'b0;
    check_val("sv_cnt", 64'(b21.sample_cnt), 64'd0);
    check_val("sv_done", 64'(b21.done), 64'd0);
    check_val("sv_busy", 64'(b21.busy), 64'd1);
    check_val("sv_sig", 64'(b21.sig), 64'd0);

    // Random runs against the queue model; odd runs expect a mismatch.
    for (int r = 0; r < 4; r++) begin
      if (r > 0) pulse_start();
      q = {};
      for (int i = 0; i < 21; i++) begin
        gap($urandom_range(0, 2));
        q.push_back(rand_y());
        send(q[$]);
      end
      rs = ref_sig(q);
      exp_sig = (r % 2 == 0) ? rs : (rs ^ 32'h0000_0100);
      check_val("rnd_sig", 64'(b21.sig), 64'(rs));
      check_val("rnd_cnt", 64'(b21.sample_cnt), 64'd21);
      step();
      check_val("rnd_done", 64'(b21.done), 64'd1);
      check_val("rnd_pass", 64'(b21.pass), (r % 2 == 0) ? 64'd1 : 64'd0);
    end

    // Reset after 10 samples abandons the run.
    pulse_start();
    for (int i = 0; i < 10; i++) send(rand_y());
    check_val("mid_cnt", 64'(b21.sample_cnt), 64'd10);
    rst = 1'b1;
    step();
    check_idle21("midrst");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      y = rand_y(); y_valid = 1'b1;
      step();
    end
    y_valid = 1'b0;
    check_idle21("idle_ignore");
    pulse_start();
    q = {};
    for (int i = 0; i < 21; i++) begin
      q.push_back(rand_y());
      send(q[$]);
    end
    rs = ref_sig(q);
    exp_sig = rs;
    step();
    check_val("post_rst_sig", 64'(b21.sig), 64'(rs));
    check_val("post_rst_done", 64'(b21.done), 64'd1);
    check_val("post_rst_pass", 64'(b21.pass), 64'd1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
